// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command/register controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_ISSUE,
    RD_CAPT,
    RD_WAIT
  } state_t;

  localparam int         CMD_RW_BIT        = 7;
  localparam logic [7:0] ERR_BYTE          = 8'hEE;
  localparam logic [7:0] STATUS_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Controller bus: SPI byte-engine handshake plus register-file port.
// master = the controller; slave = byte engine / register file side.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              i_SPI_CS_n;
  logic              i_RX_DV;
  logic [7:0]        i_RX_Byte;
  logic              o_TX_DV;
  logic [7:0]        o_TX_Byte;
  logic [ADDR_W-1:0] o_Reg_Addr;
  logic              o_Reg_Wr_En;
  logic [7:0]        o_Reg_Wr_Data;
  logic              o_Reg_Rd_En;
  logic [7:0]        i_Reg_Rd_Data;
  logic              o_Busy;
  logic              o_Err;

  modport master (
    input  i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_Reg_Rd_Data,
    output o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data,
           o_Reg_Rd_En, o_Busy, o_Err
  );

  modport slave (
    output i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_Reg_Rd_Data,
    input  o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data,
           o_Reg_Rd_En, o_Busy, o_Err
  );
endinterface

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select, with one-cycle
// fall (select) and rise (deselect) pulses.
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_CS_n,
  output logic o_CS_n_sync,
  output logic o_Fall,
  output logic o_Rise
);
  // [0],[1] are the synchronizer; [2] is the previous synced value.
  logic [2:0] sync_q;

  // Flops reset to deasserted so leaving reset never fakes a select edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], i_CS_n};
  end

  assign o_CS_n_sync = sync_q[1];
  assign o_Fall      = sync_q[2] & ~sync_q[1];
  assign o_Rise      = ~sync_q[2] & sync_q[1];
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: parses {RW,ADDR} + data bytes into register
// strokes and loads TX bytes. Optional write protect: SPI_REG_WR_PROTECT_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [6:0] RO_BASE   = 7'h60,
  parameter logic [7:0] STATUS_ID = STATUS_ID_DEFAULT
) (
  input logic            i_Clk,
  input logic            i_Rst,
  spi_reg_ctrl_if.master bus
);

`ifdef SPI_REG_WR_PROTECT_EN
  localparam bit WR_PROTECT = 1'b1;
`else
  localparam bit WR_PROTECT = 1'b0;
`endif

  logic cs_n_sync, cs_fall, cs_rise;

  spi_cs_sync u_cs_sync (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_CS_n      (bus.i_SPI_CS_n),
    .o_CS_n_sync (cs_n_sync),
    .o_Fall      (cs_fall),
    .o_Rise      (cs_rise)
  );

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic              err_q, err_d;
  logic              wr_step_q, wr_step_d;
  logic              ro_hit;

  assign ro_hit = WR_PROTECT && (addr_q >= RO_BASE[ADDR_W-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_step_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
      wr_step_q <= wr_step_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (cs_fall) state_d = CMD;
        CMD:      if (bus.i_RX_DV)
                    state_d = bus.i_RX_Byte[CMD_RW_BIT] ? RD_ISSUE : WR_DATA;
        WR_DATA:  state_d = WR_DATA;
        RD_ISSUE: state_d = RD_CAPT;
        RD_CAPT:  state_d = RD_WAIT;
        RD_WAIT:  if (bus.i_RX_DV) state_d = RD_ISSUE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Registered outputs are computed here from the current state; a deselect
  // does not cancel work already decided in this cycle.
  always_comb begin
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    wr_step_d = 1'b0;
    addr_d    = wr_step_q ? addr_q + 1'b1 : addr_q;
    case (state_q)
      IDLE: if (cs_fall) begin
        tx_dv_d   = 1'b1;
        tx_byte_d = err_q ? ERR_BYTE : STATUS_ID;
        err_d     = 1'b0;
      end
      CMD: if (bus.i_RX_DV) addr_d = bus.i_RX_Byte[ADDR_W-1:0];
      WR_DATA: if (bus.i_RX_DV) begin
        // Address steps one cycle after the strobe so the strobe sees it stable.
        wr_step_d = 1'b1;
        wr_en_d   = !ro_hit;
        wr_data_d = bus.i_RX_Byte;
        if (ro_hit) err_d = 1'b1;
      end
      RD_CAPT: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = bus.i_Reg_Rd_Data;
        addr_d    = addr_q + 1'b1;
      end
      default: ;
    endcase
    rd_en_d = (state_d == RD_ISSUE);
  end

  assign bus.o_TX_DV       = tx_dv_q;
  assign bus.o_TX_Byte     = tx_byte_q;
  assign bus.o_Reg_Addr    = addr_q;
  assign bus.o_Reg_Wr_En   = wr_en_q;
  assign bus.o_Reg_Wr_Data = wr_data_q;
  assign bus.o_Reg_Rd_En   = rd_en_q;
  assign bus.o_Busy        = ~cs_n_sync;
  assign bus.o_Err         = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: transaction-level model queues expected
// strobes with their cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

  localparam int         ADDR_W   = 7;
  localparam logic [6:0] RO_BASE  = 7'h60;
  localparam int         BYTE_GAP = 12;

`ifdef SPI_REG_WR_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  typedef enum int {EV_TX, EV_WR, EV_RD} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  spi_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_ctrl #(
    .ADDR_W    (ADDR_W),
    .RO_BASE   (RO_BASE),
    .STATUS_ID (8'hA5)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  ev_t  exp_q[$];
  logic [7:0] rf [128];
  logic [7:0] model_mem [128];
  logic model_err = 1'b0;
  logic tx_dv_prev = 1'b0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Register-file stub: read data valid exactly one cycle after Rd_En.
  always @(posedge i_Clk) begin
    if (bus.o_Reg_Wr_En) rf[bus.o_Reg_Addr] <= bus.o_Reg_Wr_Data;
    if (bus.o_Reg_Rd_En) bus.i_Reg_Rd_Data <= rf[bus.o_Reg_Addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input ev_kind_e k, input logic [6:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: addr 0x%0h data 0x%0h at cycle %0d, expected no strobe",
               k.name(), a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    if (k == e.kind) begin
      if (k != EV_TX) check($sformatf("%s_addr", k.name()), 32'(a), 32'(e.addr));
      if (k != EV_RD) check($sformatf("%s_data", k.name()), 32'(d), 32'(e.data));
      check($sformatf("%s_cycle", k.name()), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (bus.o_Reg_Wr_En || bus.o_Reg_Rd_En)
        check("one_reg_strobe", 32'(bus.o_Reg_Wr_En & bus.o_Reg_Rd_En), 32'd0);
      if (bus.o_TX_DV) check("tx_dv_not_consecutive", 32'(tx_dv_prev), 32'd0);
      if (bus.o_Reg_Wr_En) observe(EV_WR, bus.o_Reg_Addr, bus.o_Reg_Wr_Data);
      if (bus.o_Reg_Rd_En) observe(EV_RD, bus.o_Reg_Addr, 8'h00);
      if (bus.o_TX_DV)     observe(EV_TX, 7'h00, bus.o_TX_Byte);
    end
    tx_dv_prev <= bus.o_TX_DV;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Status byte appears 3 cycles after the raw CS_n fall (2 sync + 1 register).
  task automatic cs_start();
    bus.i_SPI_CS_n = 1'b0;
    push(EV_TX, 7'h00, model_err ? 8'hEE : 8'hA5, cyc + 3);
    model_err = 1'b0;
    tick(BYTE_GAP);
  endtask

  task automatic cs_end();
    bus.i_SPI_CS_n = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_Byte = b;
    bus.i_RX_DV   = 1'b1;
    tick(1);
    bus.i_RX_DV   = 1'b0;
    tick(BYTE_GAP - 1);
  endtask

  task automatic write_txn(input logic [6:0] a, input int n,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    logic [6:0] cur;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    cur = a;
    cs_start();
    send_byte({1'b0, a});
    for (int i = 0; i < n; i++) begin
      if (PROTECT && cur >= RO_BASE) begin
        model_err = 1'b1;
      end else begin
        model_mem[cur] = d[i];
        push(EV_WR, cur, d[i], cyc + 1);
      end
      send_byte(d[i]);
      cur = cur + 7'd1;
    end
    cs_end();
    check("err_after_write", 32'(bus.o_Err), 32'(model_err));
  endtask

  // Read data comes out 3 cycles after each cmd/dummy byte.
  task automatic read_txn(input logic [6:0] a, input int n_dummy);
    logic [6:0] cur;
    cur = a;
    cs_start();
    push(EV_RD, cur, 8'h00, cyc + 1);
    push(EV_TX, 7'h00, model_mem[cur], cyc + 3);
    send_byte({1'b1, a});
    for (int i = 0; i < n_dummy; i++) begin
      cur = cur + 7'd1;
      push(EV_RD, cur, 8'h00, cyc + 1);
      push(EV_TX, 7'h00, model_mem[cur], cyc + 3);
      send_byte(8'($urandom_range(0, 255)));
    end
    cs_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_SPI_CS_n    = 1'b1;
    bus.i_RX_DV       = 1'b0;
    bus.i_RX_Byte     = 8'h00;
    bus.i_Reg_Rd_Data = 8'h00;
    for (int i = 0; i < 128; i++) begin
      rf[i]        = 8'($urandom_range(0, 255));
      model_mem[i] = rf[i];
    end
    tick(3);
    check("reset_outputs",
          {4'h0, bus.o_TX_DV, bus.o_TX_Byte, bus.o_Reg_Addr, bus.o_Reg_Wr_En,
           bus.o_Reg_Wr_Data, bus.o_Reg_Rd_En, bus.o_Busy, bus.o_Err}, 32'd0);
    i_Rst = 1'b0;
    tick(4);

    // Status byte alone, busy tracking.
    cs_start();
    check("busy_in_frame", 32'(bus.o_Busy), 32'd1);
    cs_end();
    check("busy_after_frame", 32'(bus.o_Busy), 32'd0);

    write_txn(7'h05, 2, 8'h11, 8'h22, 8'h00, 8'h00);
    write_txn(7'h10, 2, 8'h3C, 8'h4D, 8'h00, 8'h00);
    read_txn(7'h10, 1);
    write_txn(7'h7F, 2, 8'hAA, 8'hBB, 8'h00, 8'h00);
    read_txn(7'h7F, 1);

`ifdef SPI_REG_WR_PROTECT_EN
    write_txn(7'h60, 1, 8'hFF, 8'h00, 8'h00, 8'h00);
    cs_start();
    check("err_cleared_by_status", 32'(bus.o_Err), 32'd0);
    cs_end();
`endif

    // Deselect while waiting for the next dummy byte.
    cs_start();
    push(EV_RD, 7'h05, 8'h00, cyc + 1);
    push(EV_TX, 7'h00, model_mem[7'h05], cyc + 3);
    send_byte(8'h85);
    cs_end();
    tick(10);
    check("abort_read_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a write burst; the in-flight byte is dropped.
    cs_start();
    send_byte(8'h20);
    model_mem[7'h20] = 8'h5A;
    push(EV_WR, 7'h20, 8'h5A, cyc + 1);
    send_byte(8'h5A);
    bus.i_RX_Byte = 8'hC3;
    bus.i_RX_DV   = 1'b1;
    i_Rst         = 1'b1;
    #1;
    check("reset_mid_write_outputs",
          {4'h0, bus.o_TX_DV, bus.o_TX_Byte, bus.o_Reg_Addr, bus.o_Reg_Wr_En,
           bus.o_Reg_Wr_Data, bus.o_Reg_Rd_En, bus.o_Busy, bus.o_Err}, 32'd0);
    bus.i_RX_DV    = 1'b0;
    bus.i_SPI_CS_n = 1'b1;
    model_err      = 1'b0;
    tick(3);
    i_Rst = 1'b0;
    tick(10);
    check("reset_abort_drained", 32'(exp_q.size()), 32'd0);
    check("reset_abort_busy", 32'(bus.o_Busy), 32'd0);
    read_txn(7'h20, 0);

    for (int t = 0; t < 30; t++) begin
      logic [6:0] a;
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1)
        read_txn(a, $urandom_range(0, 3));
      else
        write_txn(a, $urandom_range(1, 4),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    tick(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
